hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core; successor to the single load-use detector.
//  Handles load-use stalls over NUM_SRC source operands, taken-branch flushes resolved in EX,
//  and multi-cycle data-memory waits (dmem_ready handshake) with a timeout watchdog.
//  Drives all pipeline-register write enables and flushes, and keeps saturating stall/flush counters.
// PARAMETERS
//  REG_ADDR_W  5    register index width
//  NUM_SRC     2    source operands per ID instruction (3 for fused ops)
//  TIMEOUT     64   max consecutive dmem wait cycles before error; 0 = watchdog disabled
//  CNT_W       32   width of performance counters
// PORTS
//  clk              in   1                     clock, all state on rising edge
//  rst              in   1                     synchronous, active-high reset
//  rs_id            in   NUM_SRC*REG_ADDR_W    packed ID sources, src i at [i*REG_ADDR_W +: REG_ADDR_W]
//  rs_used_id       in   NUM_SRC               bit i = source i actually read by ID instruction
//  rd_ex            in   REG_ADDR_W            destination of EX instruction
//  MemRead_ex       in   1                     EX instruction is a load
//  branch_taken_ex  in   1                     branch/jump in EX resolved taken
//  mem_access_mem   in   1                     MEM instruction is load/store
//  dmem_ready       in   1                     data memory completes access this cycle
//  pc_write         out  1                     PC write enable
//  if_id_write      out  1                     IF/ID write enable
//  id_ex_write      out  1                     ID/EX write enable
//  ex_mem_write     out  1                     EX/MEM write enable
//  flush_if_id      out  1                     load NOP into IF/ID
//  flush_id_ex      out  1                     load NOP (zero controls) into ID/EX
//  flush_mem_wb     out  1                     load NOP into MEM/WB
//  mem_timeout      out  1                     sticky watchdog error
//  stall_cnt        out  CNT_W                 cycles with pc_write=0 (saturating)
//  flush_cnt        out  CNT_W                 cycles with flush_if_id=1 (saturating)
// BEHAVIOUR
//  - FSM states RUN, WAIT, ERR; reset -> RUN, mem_timeout=0, wait_ctr=0, stall_cnt=0, flush_cnt=0.
//  - While rst=1: all write enables 0, all flushes 1 (pipeline cleared), counters not incremented.
//  - Outputs combinational from state+inputs (zero latency); defaults: enables 1, flushes 0.
//  - Priority, highest first:
//    1 ERR: all enables 0, flush_mem_wb=1; stays until rst.
//    2 Mem stall (mem_access_mem & !dmem_ready): all four enables 0, flush_mem_wb=1; branch/load-use ignored (EX held).
//    3 Branch (branch_taken_ex): pc_write=1, flush_if_id=1, flush_id_ex=1; load-use ignored (wrong path).
//    4 Load-use: MemRead_ex & rd_ex!=0 & any i: rs_used_id[i] & rs_id[i]==rd_ex ->
//      pc_write=0, if_id_write=0, flush_id_ex=1; id_ex_write, ex_mem_write stay 1.
//  - RUN -> WAIT when mem stall condition true; wait_ctr <= 1.
//  - WAIT: dmem_ready=1 -> release same cycle, RUN, wait_ctr<=0; else wait_ctr++.
//  - WAIT with !dmem_ready and wait_ctr==TIMEOUT-1 (TIMEOUT>0) -> ERR, mem_timeout<=1.
//  - mem_access_mem dropping while in WAIT (abnormal) -> RUN, no stall that cycle.
//  - Counters saturate at all-ones, never wrap; increment on same edge as the counted cycle.
//  - Reset mid-WAIT or in ERR: next cycle RUN, mem_timeout=0, counters 0.
//  - TIMEOUT==1: first unready cycle enters ERR directly from RUN.
// STRUCTURE
//  - hazard_pkg: state encoding (HZ_RUN/HZ_WAIT/HZ_ERR), REG_ADDR_W default, NOP-related constants.
//  - Sub-module sat_counter (param W; inc, clr -> q) instantiated for stall_cnt and flush_cnt.
//  - Source compare loop is a generate over NUM_SRC; no other hierarchy.
// TESTING
//  1 Load-use: MemRead_ex=1, rd_ex=5, rs_id src1=5, used=2'b11 -> pc_write=0, if_id_write=0, flush_id_ex=1, stall_cnt+1.
//  2 No false stall: same but rs_used_id=2'b01, or rd_ex=0 matching rs=0 -> all enables 1, no flush.
//  3 Branch vs load-use same cycle: branch_taken_ex=1 + case 1 -> pc_write=1, flush_if_id=1, flush_id_ex=1.
//  4 Mem wait: mem_access_mem=1, dmem_ready low 3 cycles then high -> enables 0 for 3 cycles, flush_mem_wb=1, released in 4th.
//  5 Timeout: TIMEOUT=4, dmem_ready held 0 -> ERR after 4th unready cycle, mem_timeout=1 sticky; rst -> cleared.
//  6 Saturation: CNT_W=3, 9 load-use stalls -> stall_cnt=7, holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundles describe the pipeline-register enables and NOP flushes.
package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN  = 2'd0,
    HZ_WAIT = 2'd1,
    HZ_ERR  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
  } hz_ctrl_t;

  // Reset freezes every register and fills the whole pipeline with NOP bubbles.
  localparam hz_ctrl_t HZ_CTRL_RESET = '{
    pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
    flush_if_id: 1'b1, flush_id_ex: 1'b1, flush_mem_wb: 1'b1
  };

  localparam hz_ctrl_t HZ_CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
    flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_mem_wb: 1'b0
  };

  // Whole front end held; the MEM result is not ready, so WB receives a NOP.
  localparam hz_ctrl_t HZ_CTRL_HOLD = '{
    pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
    flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_mem_wb: 1'b1
  };

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX branch flushes, data-memory
// wait handshake with watchdog, plus saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
  input  logic [NUM_SRC-1:0]            rs_used_id,
  input  logic [REG_ADDR_W-1:0]         rd_ex,
  input  logic                          MemRead_ex,
  input  logic                          branch_taken_ex,
  input  logic                          mem_access_mem,
  input  logic                          dmem_ready,
  output logic                          pc_write,
  output logic                          if_id_write,
  output logic                          id_ex_write,
  output logic                          ex_mem_write,
  output logic                          flush_if_id,
  output logic                          flush_id_ex,
  output logic                          flush_mem_wb,
  output logic                          mem_timeout,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  // wait_ctr only has to reach TIMEOUT-1, the last count before the watchdog fires.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  hz_state_e         state, state_next;
  logic [WAIT_W-1:0] wait_ctr, wait_ctr_next;
  logic              timeout_next;
  logic [NUM_SRC-1:0] src_match;
  logic              load_use;
  logic              mem_stall;
  hz_ctrl_t          ctrl;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_cmp
    assign src_match[i] = rs_used_id[i] &&
                          (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == rd_ex);
  end

  assign load_use  = MemRead_ex && (rd_ex != '0) && (|src_match);
  assign mem_stall = mem_access_mem && !dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HZ_RUN;
      wait_ctr    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_ctr    <= wait_ctr_next;
      mem_timeout <= timeout_next;
    end
  end

  // wait_ctr holds the number of unready cycles already spent on the access.
  always_comb begin
    state_next    = state;
    wait_ctr_next = wait_ctr;
    timeout_next  = mem_timeout;
    case (state)
      HZ_RUN: begin
        if (mem_stall) begin
          if (TIMEOUT == 1) begin
            state_next   = HZ_ERR;
            timeout_next = 1'b1;
          end else begin
            state_next    = HZ_WAIT;
            wait_ctr_next = WAIT_W'(1);
          end
        end
      end
      HZ_WAIT: begin
        if (!mem_access_mem || dmem_ready) begin
          state_next    = HZ_RUN;
          wait_ctr_next = '0;
        end else if ((TIMEOUT > 0) && (wait_ctr == WAIT_LAST)) begin
          state_next   = HZ_ERR;
          timeout_next = 1'b1;
        end else if (TIMEOUT > 0) begin
          wait_ctr_next = wait_ctr + WAIT_W'(1);
        end
      end
      HZ_ERR: begin
        state_next = HZ_ERR;
      end
      default: begin
        state_next    = HZ_RUN;
        wait_ctr_next = '0;
      end
    endcase
  end

  // A memory hold freezes EX, so branch and load-use decisions wait with it.
  always_comb begin
    ctrl = HZ_CTRL_RUN;
    if (rst) begin
      ctrl = HZ_CTRL_RESET;
    end else if ((state == HZ_ERR) || mem_stall) begin
      ctrl = HZ_CTRL_HOLD;
    end else if (branch_taken_ex) begin
      ctrl.flush_if_id = 1'b1;
      ctrl.flush_id_ex = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.flush_id_ex = 1'b1;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_write  = ctrl.id_ex_write;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign flush_mem_wb = ctrl.flush_mem_wb;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (!ctrl.pc_write),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (ctrl.flush_if_id),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle hazard vectors
// plus hand-written memory-wait, watchdog and counter-saturation sequences.
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int NS = 2;
  localparam int TO = 4;
  localparam int CW = 3;

  // Control ordering: pc, if_id, id_ex, ex_mem, flush_if_id, flush_id_ex, flush_mem_wb
  localparam logic [6:0] C_RESET   = 7'b0000111;
  localparam logic [6:0] C_RUN     = 7'b1111000;
  localparam logic [6:0] C_HOLD    = 7'b0000001;
  localparam logic [6:0] C_BRANCH  = 7'b1111110;
  localparam logic [6:0] C_LOADUSE = 7'b0011010;

  typedef struct packed {
    logic [NS*RW-1:0] rs_id;
    logic [NS-1:0]    rs_used;
    logic [RW-1:0]    rd;
    logic             mem_read;
    logic             branch;
    logic             mem_access;
    logic             ready;
    logic [6:0]       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS*RW-1:0] rs_id = '0;
  logic [NS-1:0]    rs_used_id = '0;
  logic [RW-1:0]    rd_ex = '0;
  logic MemRead_ex = 1'b0;
  logic branch_taken_ex = 1'b0;
  logic mem_access_mem = 1'b0;
  logic dmem_ready = 1'b0;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic flush_if_id, flush_id_ex, flush_mem_wb, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctrl_obs;

  int checks = 0;
  int errors = 0;
  vec_t vecs[10];

  hazard_ctrl #(
    .REG_ADDR_W (RW),
    .NUM_SRC    (NS),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_id           (rs_id),
    .rs_used_id      (rs_used_id),
    .rd_ex           (rd_ex),
    .MemRead_ex      (MemRead_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_access_mem  (mem_access_mem),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .flush_mem_wb    (flush_mem_wb),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                     flush_if_id, flush_id_ex, flush_mem_wb};

  function automatic vec_t mk(input logic [RW-1:0] s1, input logic [RW-1:0] s0,
                              input logic [NS-1:0] used, input logic [RW-1:0] rd,
                              input logic mr, input logic br, input logic ma,
                              input logic dr, input logic [6:0] exp);
    vec_t v;
    v.rs_id      = {s1, s0};
    v.rs_used    = used;
    v.rd         = rd;
    v.mem_read   = mr;
    v.branch     = br;
    v.mem_access = ma;
    v.ready      = dr;
    v.exp        = exp;
    return v;
  endfunction

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rs_id           = v.rs_id;
    rs_used_id      = v.rs_used;
    rd_ex           = v.rd;
    MemRead_ex      = v.mem_read;
    branch_taken_ex = v.branch;
    mem_access_mem  = v.mem_access;
    dmem_ready      = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    #2;
    checks++;
    if (ctrl_obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: ctrl=%b expected %b", name, ctrl_obs, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset(input string name);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RESET));
    rst = 1'b1;
    checkOutput(name, C_RESET);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;

    vecs[0] = mk(5'd5, 5'd3, 2'b11, 5'd5, 1, 0, 0, 0, C_LOADUSE);
    vecs[1] = mk(5'd5, 5'd3, 2'b01, 5'd5, 1, 0, 0, 0, C_RUN);
    vecs[2] = mk(5'd0, 5'd0, 2'b11, 5'd0, 1, 0, 0, 0, C_RUN);
    vecs[3] = mk(5'd5, 5'd3, 2'b11, 5'd5, 0, 0, 0, 0, C_RUN);
    vecs[4] = mk(5'd5, 5'd3, 2'b11, 5'd5, 1, 1, 0, 0, C_BRANCH);
    vecs[5] = mk(5'd1, 5'd9, 2'b01, 5'd9, 1, 0, 0, 0, C_LOADUSE);
    vecs[6] = mk(5'd1, 5'd9, 2'b10, 5'd9, 1, 0, 0, 0, C_RUN);
    vecs[7] = mk(5'd12, 5'd4, 2'b11, 5'd12, 1, 0, 1, 1, C_LOADUSE);
    vecs[8] = mk(5'd0, 5'd0, 2'b00, 5'd0, 0, 1, 0, 0, C_BRANCH);
    vecs[9] = mk(5'd31, 5'd31, 2'b11, 5'd31, 1, 0, 0, 0, C_LOADUSE);

    doReset("reset_outputs");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    checkOutput("idle_after_reset", C_RUN);
    checkValue("reset_mem_timeout", int'(mem_timeout), 0);
    checkValue("reset_stall_cnt", int'(stall_cnt), 0);
    checkValue("reset_flush_cnt", int'(flush_cnt), 0);

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      if (!vecs[i].exp[6] && exp_stall < 7) exp_stall++;
      if (vecs[i].exp[2] && exp_flush < 7) exp_flush++;
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    checkOutput("idle_after_table", C_RUN);
    checkValue("table_stall_cnt", int'(stall_cnt), exp_stall);
    checkValue("table_flush_cnt", int'(flush_cnt), exp_flush);

    // Three unready cycles with branch and load-use pending, released on the fourth.
    doReset("reset_before_wait");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mk(5'd5, 5'd0, 2'b11, 5'd5, 1, 1, 1, 0, C_HOLD));
      checkOutput($sformatf("mem_wait%0d", k), C_HOLD);
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1, C_RUN));
    checkOutput("mem_release", C_RUN);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    checkOutput("after_release", C_RUN);
    checkValue("wait_stall_cnt", int'(stall_cnt), 3);
    checkValue("wait_flush_cnt", int'(flush_cnt), 0);
    checkValue("wait_no_timeout", int'(mem_timeout), 0);

    // Access withdrawn mid-wait: back to normal hazard handling at once.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, C_HOLD));
    checkOutput("drop_wait", C_HOLD);
    applyStimulus(mk(5'd7, 5'd0, 2'b10, 5'd7, 1, 0, 0, 0, C_LOADUSE));
    checkOutput("drop_loaduse", C_LOADUSE);

    // Watchdog: four unready cycles, then ERR is sticky until reset.
    doReset("reset_before_timeout");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, C_HOLD));
      checkOutput($sformatf("to_wait%0d", k), C_HOLD);
      checkValue($sformatf("to_pending%0d", k), int'(mem_timeout), 0);
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, C_HOLD));
    checkOutput("err_hold", C_HOLD);
    checkValue("err_timeout", int'(mem_timeout), 1);
    applyStimulus(mk(5'd5, 5'd0, 2'b11, 5'd5, 1, 1, 0, 1, C_HOLD));
    checkOutput("err_sticky", C_HOLD);
    checkValue("err_timeout_sticky", int'(mem_timeout), 1);
    doReset("reset_from_err");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    checkOutput("run_after_err", C_RUN);
    checkValue("err_cleared", int'(mem_timeout), 0);
    checkValue("err_stall_cnt_cleared", int'(stall_cnt), 0);

    // Nine load-use stalls on a 3-bit counter.
    doReset("reset_before_sat");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(mk(5'd6, 5'd2, 2'b11, 5'd6, 1, 0, 0, 0, C_LOADUSE));
      checkOutput($sformatf("sat_lu%0d", k), C_LOADUSE);
      checkValue($sformatf("sat_cnt%0d", k), int'(stall_cnt), (k < 7) ? k : 7);
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN));
    checkOutput("sat_idle", C_RUN);
    checkValue("sat_final", int'(stall_cnt), 7);
    checkValue("sat_flush_cnt", int'(flush_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
